change_dispenser: RTL and testbench

Downstream consumer of the vending controller's change output. On a one-cycle `start`, it latches the change amount and pays it out as a sequence of timed coin-ejector pulses ($5, $2, $1), greedy by denomination. It tracks a per-denomination coin stock and reports completion, including any unpaid shortfall, back to the controller. It sits inside `vending_machine_top` between the controller's `change_due` and the board's coin-ejector outputs and LEDs.

---
 rtl/change_dispenser_pkg.sv | 28 ++
 rtl/change_dispenser_timer.sv | 26 ++
 rtl/change_dispenser.sv | 109 ++++++++++
 tb/tb_change_dispenser.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared constants for the coin change dispenser
package change_dispenser_pkg;

    localparam logic [7:0] DENOM_5 = 8'd5;
    localparam logic [7:0] DENOM_2 = 8'd2;
    localparam logic [7:0] DENOM_1 = 8'd1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_PULSE  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int EMPTY5_BIT = 2;
    localparam int EMPTY2_BIT = 1;
    localparam int EMPTY1_BIT = 0;

    localparam int TIMER_W = 8;

    // Greedy choice: largest in-stock coin not exceeding the balance, 0 when none fits.
    function automatic logic [7:0] pick_denom(input logic [7:0] rem, input logic [2:0] avail);
        if (rem >= DENOM_5 && avail[EMPTY5_BIT]) return DENOM_5;
        if (rem >= DENOM_2 && avail[EMPTY2_BIT]) return DENOM_2;
        if (rem >= DENOM_1 && avail[EMPTY1_BIT]) return DENOM_1;
        return 8'd0;
    endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// rtl/change_dispenser_timer.sv - loadable down-counter timing pulse and gap intervals
module dispense_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= count;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout FSM with per-denomination stock
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 4,
    parameter int INIT_COIN5   = 4,
    parameter int INIT_COIN2   = 4,
    parameter int INIT_COIN1   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       restock,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] remaining,
    output logic       coin5_out,
    output logic       coin2_out,
    output logic       coin1_out,
    output logic [2:0] coin_empty
);

    logic [2:0]         state;
    logic [7:0]         active_d;
    logic [CNT_W-1:0]   stock5, stock2, stock1;
    logic [7:0]         pick;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expired;

    assign coin_empty[EMPTY5_BIT] = (stock5 == '0);
    assign coin_empty[EMPTY2_BIT] = (stock2 == '0);
    assign coin_empty[EMPTY1_BIT] = (stock1 == '0);

    assign pick = pick_denom(remaining, ~coin_empty);

    // Timer is loaded with N-1 so that the state dwells exactly N cycles.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        if (state == ST_SELECT && pick != 8'd0) begin
            timer_load = 1'b1;
            timer_val  = TIMER_W'(PULSE_CYCLES - 1);
        end else if (state == ST_PULSE && timer_expired) begin
            timer_load = 1'b1;
            timer_val  = TIMER_W'(GAP_CYCLES - 1);
        end
    end

    dispense_timer #(.W(TIMER_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .count   (timer_val),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= 8'd0;
            active_d  <= 8'd0;
            stock5    <= CNT_W'(INIT_COIN5);
            stock2    <= CNT_W'(INIT_COIN2);
            stock1    <= CNT_W'(INIT_COIN1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SELECT;
                        remaining <= amount;
                    end else if (restock) begin
                        stock5 <= CNT_W'(INIT_COIN5);
                        stock2 <= CNT_W'(INIT_COIN2);
                        stock1 <= CNT_W'(INIT_COIN1);
                    end
                end
                ST_SELECT: begin
                    if (pick != 8'd0) begin
                        state     <= ST_PULSE;
                        remaining <= remaining - pick;
                        active_d  <= pick;
                        if (pick == DENOM_5) stock5 <= stock5 - CNT_W'(1);
                        if (pick == DENOM_2) stock2 <= stock2 - CNT_W'(1);
                        if (pick == DENOM_1) stock1 <= stock1 - CNT_W'(1);
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_PULSE: if (timer_expired) state <= ST_GAP;
                ST_GAP:   if (timer_expired) state <= ST_SELECT;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign short     = done && (remaining != 8'd0);
    assign coin5_out = (state == ST_PULSE) && (active_d == DENOM_5);
    assign coin2_out = (state == ST_PULSE) && (active_d == DENOM_2);
    assign coin1_out = (state == ST_PULSE) && (active_d == DENOM_1);

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst, start, restock;
    logic [7:0] amount;
    logic       busy, done, short;
    logic [7:0] remaining;
    logic       coin5_out, coin2_out, coin1_out;
    logic [2:0] coin_empty;

    int n_vec = 0;
    int n_err = 0;
    int m_stock[3];
    int denoms[3] = '{5, 2, 1};

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .amount     (amount),
        .restock    (restock),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .remaining  (remaining),
        .coin5_out  (coin5_out),
        .coin2_out  (coin2_out),
        .coin1_out  (coin1_out),
        .coin_empty (coin_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_empty();
        return {m_stock[0] == 0, m_stock[1] == 0, m_stock[2] == 0};
    endfunction

    task automatic check_stocks(input string tag);
        check({tag, "_stock5"}, 32'(dut.stock5), m_stock[0]);
        check({tag, "_stock2"}, 32'(dut.stock2), m_stock[1]);
        check({tag, "_stock1"}, 32'(dut.stock1), m_stock[2]);
    endtask

    task automatic restock_idle();
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        m_stock = '{4, 4, 4};
        check("restock_empty", coin_empty, 3'b000);
        check_stocks("restock");
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
    task automatic run_payout(input int amt, input bit poke);
        int coins[$];
        logic [2:0] emp[$];
        int rem, n, cyc_done, k, idx, ne;
        bit found;
        logic [2:0] ec;
        rem = amt;
        emp.push_back(model_empty());
        found = 1'b1;
        while (rem > 0 && found) begin
            found = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (!found && denoms[d] <= rem && m_stock[d] > 0) begin
                    coins.push_back(denoms[d]);
                    m_stock[d]--;
                    rem -= denoms[d];
                    found = 1'b1;
                end
            end
            if (found) emp.push_back(model_empty());
        end
        n = coins.size();
        cyc_done = 2 + 7 * n;

        start  = 1'b1;
        amount = 8'(amt);
        for (int c = 1; c <= cyc_done + 1; c++) begin
            @(negedge clk);
            ec = 3'b000;
            if (c >= 2) begin
                k   = c - 2;
                idx = k / 7;
                if (idx < n && (k % 7) < 4) begin
                    case (coins[idx])
                        5:       ec = 3'b100;
                        2:       ec = 3'b010;
                        default: ec = 3'b001;
                    endcase
                end
            end
            ne = (c < 2) ? 0 : ((c - 2) / 7 + 1);
            if (ne > n) ne = n;
            check("coins", {coin5_out, coin2_out, coin1_out}, ec);
            check("busy", busy, c <= cyc_done);
            check("done", done, c == cyc_done);
            check("coin_empty", coin_empty, emp[ne]);
            if (c == 1) check("remaining_load", remaining, amt);
            if (c == cyc_done) begin
                check("short", short, rem != 0);
                check("remaining_done", remaining, rem);
            end
            if (c == cyc_done + 1) check("remaining_hold", remaining, rem);
            start   = 1'b0;
            restock = 1'b0;
            if (poke && n > 0 && c == 4) begin
                start   = 1'b1;
                amount  = 8'd3;
                restock = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; restock = 1'b0; amount = 8'd0;
        m_stock = '{4, 4, 4};
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_coins", {coin5_out, coin2_out, coin1_out}, 3'b000);
        check("rst_remaining", remaining, 8'd0);
        check("rst_empty", coin_empty, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        run_payout(8, 1'b0);
        check_stocks("after8");
        run_payout(0, 1'b0);

        restock_idle();
        repeat (4) run_payout(1, 1'b0);
        run_payout(6, 1'b0);

        run_payout(7, 1'b1);
        check_stocks("after_poke");
        restock_idle();

        start  = 1'b1;
        amount = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pulse_before_rst", coin5_out, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_stock = '{4, 4, 4};
        check("midrst_coin5", coin5_out, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_remaining", remaining, 8'd0);
        check_stocks("midrst");
        run_payout(2, 1'b0);

        repeat (25) begin
            if ($urandom_range(0, 3) == 0) restock_idle();
            run_payout(int'($urandom_range(0, 20)), $urandom_range(0, 1) == 1);
        end
        check_stocks("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
